// File: rtl/rob_multi.sv
// rob_multi: reorder buffer with NUM_WB writeback channels and in-order commit of up to COMMIT_W entries per cycle.
// Define ROB_WB_BYPASS_EN to forward same-cycle writeback results to the operand lookup ports.
module rob_multi #(
  parameter int DEPTH_LOG2 = 4,
  parameter int NUM_WB     = 3,
  parameter int COMMIT_W   = 2,
  parameter int DATA_W     = 32,
  parameter int ADDR_W     = 32,
  parameter int ID_W       = 6,
  parameter int RD_W       = 5
) (
  input  logic                         clk_in,
  input  logic                         rst_n_in,
  input  logic                         rdy_in,
  input  logic                         clear_branch_in,
  input  logic                         issue_en_in,
  input  logic [ID_W-1:0]              issue_id_in,
  input  logic [RD_W-1:0]              issue_rd_in,
  input  logic                         issue_store_in,
  input  logic [ADDR_W-1:0]            issue_pc_in,
  output logic [DEPTH_LOG2-1:0]        tail_out,
  output logic [DEPTH_LOG2-1:0]        head_out,
  output logic                         full_out,
  output logic                         empty_out,
  input  logic [NUM_WB-1:0]            wb_en_in,
  input  logic [NUM_WB*DEPTH_LOG2-1:0] wb_pos_in,
  input  logic [NUM_WB*DATA_W-1:0]     wb_res_in,
  input  logic [NUM_WB-1:0]            wb_jump_en_in,
  input  logic [NUM_WB*ADDR_W-1:0]     wb_jump_a_in,
  input  logic [DEPTH_LOG2-1:0]        rs1_pos_in,
  input  logic [DEPTH_LOG2-1:0]        rs2_pos_in,
  output logic                         rs1_stall_out,
  output logic                         rs2_stall_out,
  output logic [DATA_W-1:0]            rs1_res_out,
  output logic [DATA_W-1:0]            rs2_res_out,
  output logic [COMMIT_W-1:0]          commit_en_out,
  output logic [COMMIT_W*DEPTH_LOG2-1:0] commit_pos_out,
  output logic [COMMIT_W*ID_W-1:0]     commit_id_out,
  output logic [COMMIT_W*RD_W-1:0]     commit_rd_out,
  output logic [COMMIT_W*DATA_W-1:0]   commit_res_out,
  output logic [COMMIT_W-1:0]          commit_jump_en_out,
  output logic [COMMIT_W*ADDR_W-1:0]   commit_jump_a_out
);

  localparam int DEPTH = 1 << DEPTH_LOG2;
  localparam int CNT_W = DEPTH_LOG2 + 1;

  logic [DEPTH_LOG2-1:0] head_q, head_d, tail_q, tail_d;
  logic [CNT_W-1:0]      count_q, count_d, n_commit;
  logic [DEPTH-1:0]      valid_q, valid_d, ready_q, ready_d;
  logic [DEPTH-1:0]      store_q, store_d, jmp_q, jmp_d;
  logic [ID_W-1:0]       id_q   [DEPTH];
  logic [ID_W-1:0]       id_d   [DEPTH];
  logic [RD_W-1:0]       rd_q   [DEPTH];
  logic [RD_W-1:0]       rd_d   [DEPTH];
  logic [DATA_W-1:0]     res_q  [DEPTH];
  logic [DATA_W-1:0]     res_d  [DEPTH];
  logic [ADDR_W-1:0]     jmpa_q [DEPTH];
  logic [ADDR_W-1:0]     jmpa_d [DEPTH];

  logic [COMMIT_W-1:0]            c_en_q, c_en_d, c_jen_q, c_jen_d;
  logic [COMMIT_W*DEPTH_LOG2-1:0] c_pos_q, c_pos_d;
  logic [COMMIT_W*ID_W-1:0]       c_id_q, c_id_d;
  logic [COMMIT_W*RD_W-1:0]       c_rd_q, c_rd_d;
  logic [COMMIT_W*DATA_W-1:0]     c_res_q, c_res_d;
  logic [COMMIT_W*ADDR_W-1:0]     c_ja_q, c_ja_d;

  logic issue_ok;

  assign full_out  = (count_q == CNT_W'(DEPTH));
  assign empty_out = (count_q == '0);
  assign head_out  = head_q;
  assign tail_out  = tail_q;
  assign issue_ok  = issue_en_in && !full_out;

  always_comb begin
    logic [DEPTH_LOG2-1:0] idx;
    logic [DEPTH_LOG2-1:0] wpos;
    logic                  fire;
    logic                  blocked;
    idx      = '0;
    wpos     = '0;
    fire     = 1'b0;
    blocked  = 1'b0;
    n_commit = '0;
    tail_d   = tail_q;
    valid_d  = valid_q;
    ready_d  = ready_q;
    store_d  = store_q;
    jmp_d    = jmp_q;
    id_d     = id_q;
    rd_d     = rd_q;
    res_d    = res_q;
    jmpa_d   = jmpa_q;
    c_en_d   = '0;
    c_jen_d  = '0;
    c_pos_d  = '0;
    c_id_d   = '0;
    c_rd_d   = '0;
    c_res_d  = '0;
    c_ja_d   = '0;

    if (issue_ok) begin
      valid_d[tail_q] = 1'b1;
      ready_d[tail_q] = 1'b0;
      jmp_d[tail_q]   = 1'b0;
      store_d[tail_q] = issue_store_in;
      id_d[tail_q]    = issue_id_in;
      rd_d[tail_q]    = issue_rd_in;
      jmpa_d[tail_q]  = issue_pc_in;
      tail_d          = tail_q + DEPTH_LOG2'(1);
    end

    // Ascending channel order lets the highest channel win on a shared pos.
    for (int c = 0; c < NUM_WB; c++) begin
      wpos = wb_pos_in[c*DEPTH_LOG2 +: DEPTH_LOG2];
      if (wb_en_in[c] && valid_q[wpos]) begin
        ready_d[wpos] = 1'b1;
        res_d[wpos]   = wb_res_in[c*DATA_W +: DATA_W];
        jmp_d[wpos]   = wb_jump_en_in[c];
        jmpa_d[wpos]  = wb_jump_a_in[c*ADDR_W +: ADDR_W];
      end
    end

    for (int k = 0; k < COMMIT_W; k++) begin
      idx  = head_q + DEPTH_LOG2'(k);
      fire = !blocked && (CNT_W'(k) < count_q) && valid_q[idx] && ready_q[idx];
      if (fire) begin
        c_en_d[k]                             = 1'b1;
        c_jen_d[k]                            = jmp_q[idx];
        c_pos_d[k*DEPTH_LOG2 +: DEPTH_LOG2]   = idx;
        c_id_d[k*ID_W +: ID_W]                = id_q[idx];
        c_rd_d[k*RD_W +: RD_W]                = rd_q[idx];
        c_res_d[k*DATA_W +: DATA_W]           = res_q[idx];
        c_ja_d[k*ADDR_W +: ADDR_W]            = jmpa_q[idx];
        valid_d[idx]                          = 1'b0;
        ready_d[idx]                          = 1'b0;
        n_commit                              = n_commit + CNT_W'(1);
      end
      blocked = blocked || !fire || jmp_q[idx] || store_q[idx];
    end

    head_d  = head_q + n_commit[DEPTH_LOG2-1:0];
    count_d = count_q + CNT_W'(issue_ok) - n_commit;
  end

  always_ff @(posedge clk_in) begin
    if (!rst_n_in || (rdy_in && clear_branch_in)) begin
      head_q  <= '0;
      tail_q  <= '0;
      count_q <= '0;
      valid_q <= '0;
      ready_q <= '0;
      c_en_q  <= '0;
      c_jen_q <= '0;
      c_pos_q <= '0;
      c_id_q  <= '0;
      c_rd_q  <= '0;
      c_res_q <= '0;
      c_ja_q  <= '0;
    end else if (rdy_in) begin
      head_q  <= head_d;
      tail_q  <= tail_d;
      count_q <= count_d;
      valid_q <= valid_d;
      ready_q <= ready_d;
      c_en_q  <= c_en_d;
      c_jen_q <= c_jen_d;
      c_pos_q <= c_pos_d;
      c_id_q  <= c_id_d;
      c_rd_q  <= c_rd_d;
      c_res_q <= c_res_d;
      c_ja_q  <= c_ja_d;
    end
  end

  // Payload is only meaningful behind valid/ready, so it needs no reset.
  always_ff @(posedge clk_in) begin
    if (rst_n_in && rdy_in && !clear_branch_in) begin
      store_q <= store_d;
      jmp_q   <= jmp_d;
      id_q    <= id_d;
      rd_q    <= rd_d;
      res_q   <= res_d;
      jmpa_q  <= jmpa_d;
    end
  end

  assign commit_en_out      = c_en_q;
  assign commit_jump_en_out = c_jen_q;
  assign commit_pos_out     = c_pos_q;
  assign commit_id_out      = c_id_q;
  assign commit_rd_out      = c_rd_q;
  assign commit_res_out     = c_res_q;
  assign commit_jump_a_out  = c_ja_q;

  logic [DEPTH_LOG2-1:0] rs_pos   [2];
  logic                  rs_stall [2];
  logic [DATA_W-1:0]     rs_res   [2];

  assign rs_pos[0] = rs1_pos_in;
  assign rs_pos[1] = rs2_pos_in;

  always_comb begin
    for (int r = 0; r < 2; r++) begin
      rs_stall[r] = !(valid_q[rs_pos[r]] && ready_q[rs_pos[r]]);
      rs_res[r]   = res_q[rs_pos[r]];
`ifdef ROB_WB_BYPASS_EN
      for (int c = 0; c < NUM_WB; c++) begin
        if (wb_en_in[c] && (wb_pos_in[c*DEPTH_LOG2 +: DEPTH_LOG2] == rs_pos[r])) begin
          rs_stall[r] = 1'b0;
          rs_res[r]   = wb_res_in[c*DATA_W +: DATA_W];
        end
      end
`endif
    end
  end

  assign rs1_stall_out = rs_stall[0];
  assign rs2_stall_out = rs_stall[1];
  assign rs1_res_out   = rs_res[0];
  assign rs2_res_out   = rs_res[1];

endmodule

// File: tb/tb_rob_multi.sv
// tb_rob_multi: directed and randomized checks of rob_multi against a queue-of-entries model.
`timescale 1ns/1ps
module tb_rob_multi;
  localparam int DL = 4, DEPTH = 16, NWB = 3, CW = 2, DW = 32, AW = 32, IW = 6, RW = 5;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic              rstN, rdy, clr, issueEn, issueStore;
  logic [IW-1:0]     issueId;
  logic [RW-1:0]     issueRd;
  logic [AW-1:0]     issuePc;
  logic [DL-1:0]     tailOut, headOut, rs1Pos, rs2Pos;
  logic              fullOut, emptyOut, rs1Stall, rs2Stall;
  logic [DW-1:0]     rs1Res, rs2Res;
  logic [NWB-1:0]    wbEn, wbJen;
  logic [NWB*DL-1:0] wbPos;
  logic [NWB*DW-1:0] wbRes;
  logic [NWB*AW-1:0] wbJa;
  logic [CW-1:0]     cEn, cJen;
  logic [CW*DL-1:0]  cPos;
  logic [CW*IW-1:0]  cId;
  logic [CW*RW-1:0]  cRd;
  logic [CW*DW-1:0]  cRes;
  logic [CW*AW-1:0]  cJa;

  rob_multi dut (
    .clk_in(clk), .rst_n_in(rstN), .rdy_in(rdy), .clear_branch_in(clr),
    .issue_en_in(issueEn), .issue_id_in(issueId), .issue_rd_in(issueRd),
    .issue_store_in(issueStore), .issue_pc_in(issuePc),
    .tail_out(tailOut), .head_out(headOut), .full_out(fullOut), .empty_out(emptyOut),
    .wb_en_in(wbEn), .wb_pos_in(wbPos), .wb_res_in(wbRes),
    .wb_jump_en_in(wbJen), .wb_jump_a_in(wbJa),
    .rs1_pos_in(rs1Pos), .rs2_pos_in(rs2Pos),
    .rs1_stall_out(rs1Stall), .rs2_stall_out(rs2Stall),
    .rs1_res_out(rs1Res), .rs2_res_out(rs2Res),
    .commit_en_out(cEn), .commit_pos_out(cPos), .commit_id_out(cId),
    .commit_rd_out(cRd), .commit_res_out(cRes),
    .commit_jump_en_out(cJen), .commit_jump_a_out(cJa)
  );

  typedef struct {
    logic [IW-1:0] id;
    logic [RW-1:0] rd;
    logic          store;
    logic          ready;
    logic [DW-1:0] res;
    logic          jen;
    logic [AW-1:0] ja;
  } ent_t;

  // Oldest entry at q[0]; its buffer index is mHead.
  ent_t          q[$];
  int            mHead;
  logic [CW-1:0] expEn, expJen;
  logic [DL-1:0] expPos [CW];
  logic [IW-1:0] expId  [CW];
  logic [RW-1:0] expRd  [CW];
  logic [DW-1:0] expRes [CW];
  logic [AW-1:0] expJa  [CW];
  bit            expZero;
  int            tests = 0;
  int            fails = 0;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("[TB] FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic zeroCommit();
    expEn = '0;
    expJen = '0;
    for (int k = 0; k < CW; k++) begin
      expPos[k] = '0; expId[k] = '0; expRd[k] = '0; expRes[k] = '0; expJa[k] = '0;
    end
  endtask

  task automatic modelStep();
    int   n;
    int   off;
    bit   wasFull;
    ent_t e;
    if (!rstN || (rdy && clr)) begin
      q.delete();
      mHead = 0;
      zeroCommit();
      expZero = 1;
    end else if (rdy) begin
      wasFull = (q.size() == DEPTH);
      zeroCommit();
      expZero = 0;
      n = 0;
      for (int k = 0; k < CW; k++) begin
        if (k >= q.size() || !q[k].ready) break;
        expEn[k] = 1'b1;
        expJen[k] = q[k].jen;
        expPos[k] = DL'((mHead + k) % DEPTH);
        expId[k] = q[k].id;
        expRd[k] = q[k].rd;
        expRes[k] = q[k].res;
        expJa[k] = q[k].ja;
        n++;
        if (q[k].jen || q[k].store) break;
      end
      for (int c = 0; c < NWB; c++) begin
        if (wbEn[c]) begin
          off = (int'(wbPos[c*DL +: DL]) - mHead + DEPTH) % DEPTH;
          if (off < q.size()) begin
            q[off].ready = 1'b1;
            q[off].res = wbRes[c*DW +: DW];
            q[off].jen = wbJen[c];
            q[off].ja = wbJa[c*AW +: AW];
          end
        end
      end
      repeat (n) void'(q.pop_front());
      mHead = (mHead + n) % DEPTH;
      if (issueEn && !wasFull) begin
        e.id = issueId; e.rd = issueRd; e.store = issueStore;
        e.ready = 1'b0; e.res = '0; e.jen = 1'b0; e.ja = '0;
        q.push_back(e);
      end
    end
  endtask

  task automatic lookupExp(input logic [DL-1:0] pos, output logic stall, output logic [DW-1:0] res);
    int off;
    off = (int'(pos) - mHead + DEPTH) % DEPTH;
    stall = 1'b1;
    res = '0;
    if (off < q.size() && q[off].ready) begin
      stall = 1'b0;
      res = q[off].res;
    end
`ifdef ROB_WB_BYPASS_EN
    for (int c = 0; c < NWB; c++) begin
      if (wbEn[c] && wbPos[c*DL +: DL] == pos) begin
        stall = 1'b0;
        res = wbRes[c*DW +: DW];
      end
    end
`endif
  endtask

  task automatic checkLookup();
    logic          s;
    logic [DW-1:0] r;
    lookupExp(rs1Pos, s, r);
    check("rs1_stall", 64'(rs1Stall), 64'(s));
    if (!s) check("rs1_res", 64'(rs1Res), 64'(r));
    lookupExp(rs2Pos, s, r);
    check("rs2_stall", 64'(rs2Stall), 64'(s));
    if (!s) check("rs2_res", 64'(rs2Res), 64'(r));
  endtask

  task automatic checkOutput();
    check("head", 64'(headOut), 64'(mHead));
    check("tail", 64'(tailOut), 64'((mHead + q.size()) % DEPTH));
    check("full", 64'(fullOut), 64'(q.size() == DEPTH));
    check("empty", 64'(emptyOut), 64'(q.size() == 0));
    check("commit_en", 64'(cEn), 64'(expEn));
    for (int k = 0; k < CW; k++) begin
      if (expEn[k] || expZero) begin
        check($sformatf("c%0d_pos", k), 64'(cPos[k*DL +: DL]), 64'(expPos[k]));
        check($sformatf("c%0d_id", k), 64'(cId[k*IW +: IW]), 64'(expId[k]));
        check($sformatf("c%0d_rd", k), 64'(cRd[k*RW +: RW]), 64'(expRd[k]));
        check($sformatf("c%0d_res", k), 64'(cRes[k*DW +: DW]), 64'(expRes[k]));
        check($sformatf("c%0d_jen", k), 64'(cJen[k]), 64'(expJen[k]));
        check($sformatf("c%0d_ja", k), 64'(cJa[k*AW +: AW]), 64'(expJa[k]));
      end
    end
  endtask

  // One clock: lookup check before the edge, model update, registered check after it.
  task automatic applyStimulus();
    #1;
    if (rstN) checkLookup();
    modelStep();
    @(posedge clk);
    #1;
    checkOutput();
    issueEn = 1'b0;
    wbEn = '0;
    wbJen = '0;
    clr = 1'b0;
    @(negedge clk);
  endtask

  task automatic setIssue(input logic store);
    issueEn = 1'b1;
    issueId = IW'($urandom);
    issueRd = RW'($urandom);
    issuePc = $urandom;
    issueStore = store;
  endtask

  task automatic setWb(input int c, input int pos, input logic [DW-1:0] res,
                       input logic jen, input logic [AW-1:0] ja);
    wbEn[c] = 1'b1;
    wbPos[c*DL +: DL] = DL'(pos);
    wbRes[c*DW +: DW] = res;
    wbJen[c] = jen;
    wbJa[c*AW +: AW] = ja;
  endtask

  initial begin
    rstN = 1'b0; rdy = 1'b1; clr = 1'b0; issueEn = 1'b0; issueStore = 1'b0;
    issueId = '0; issueRd = '0; issuePc = '0; rs1Pos = '0; rs2Pos = '0;
    wbEn = '0; wbJen = '0; wbPos = '0; wbRes = '0; wbJa = '0;
    q.delete(); mHead = 0; zeroCommit(); expZero = 1;

    applyStimulus();
    applyStimulus();
    rstN = 1'b1;
    for (int i = 0; i < 3; i++) begin setIssue(1'b0); applyStimulus(); end
    check("tp_tail3", 64'(tailOut), 64'd3);
    check("tp_empty0", 64'(emptyOut), 64'd0);

    for (int i = 0; i < 14; i++) begin setIssue(1'b0); applyStimulus(); end
    check("tp_full", 64'(fullOut), 64'd1);
    check("tp_tail_wrap", 64'(tailOut), 64'd0);

    setWb(0, 0, 32'h11, 1'b0, 32'h0);
    setWb(1, 1, 32'h22, 1'b0, 32'h0);
    applyStimulus();
    setIssue(1'b0);
    applyStimulus();
    check("tp_commit_two", 64'(cEn), 64'd3);
    check("tp_head2", 64'(headOut), 64'd2);

    setWb(0, 2, 32'h33, 1'b1, 32'h100);
    setWb(1, 3, 32'h44, 1'b0, 32'h0);
    applyStimulus();
    applyStimulus();
    check("tp_jump_only", 64'(cEn), 64'd1);
    check("tp_jump_a", 64'(cJa[AW-1:0]), 64'h100);
    applyStimulus();
    check("tp_after_jump", 64'(cEn), 64'd1);
    check("tp_after_jump_pos", 64'(cPos[DL-1:0]), 64'd3);

    setWb(0, 5, 32'hA, 1'b0, 32'h0);
    setWb(1, 1, 32'hDEAD, 1'b0, 32'h0);
    setWb(2, 5, 32'hB, 1'b0, 32'h0);
    applyStimulus();
    rs1Pos = 4'd5;
    rs2Pos = 4'd1;
    applyStimulus();
    check("tp_res_hi_chan", 64'(rs1Res), 64'hB);
    check("tp_invalid_wb", 64'(rs2Stall), 64'd1);

    rs1Pos = 4'd6;
    setWb(0, 6, 32'h55, 1'b0, 32'h0);
    #1;
`ifdef ROB_WB_BYPASS_EN
    check("tp_bypass_stall", 64'(rs1Stall), 64'd0);
    check("tp_bypass_res", 64'(rs1Res), 64'h55);
`else
    check("tp_nobypass_stall", 64'(rs1Stall), 64'd1);
`endif
    applyStimulus();

    clr = 1'b1;
    setIssue(1'b0);
    setWb(0, 7, 32'h77, 1'b0, 32'h0);
    applyStimulus();
    check("tp_clear_empty", 64'(emptyOut), 64'd1);
    check("tp_clear_commit", 64'(cEn), 64'd0);
    setIssue(1'b0);
    applyStimulus();
    check("tp_issue_idx0", 64'(tailOut), 64'd1);

    rdy = 1'b0;
    setIssue(1'b1);
    setWb(0, 0, 32'h99, 1'b0, 32'h0);
    applyStimulus();
    rdy = 1'b1;

    for (int i = 0; i < 600; i++) begin
      rstN = ($urandom_range(0, 199) != 0);
      rdy = ($urandom_range(0, 9) != 0);
      clr = ($urandom_range(0, 59) == 0);
      if ($urandom_range(0, 9) < 6) setIssue($urandom_range(0, 5) == 0);
      for (int c = 0; c < NWB; c++) begin
        if ($urandom_range(0, 1) == 1)
          setWb(c, (mHead + $urandom_range(0, q.size())) % DEPTH, $urandom,
                $urandom_range(0, 7) == 0, $urandom);
      end
      rs1Pos = DL'($urandom);
      rs2Pos = DL'((mHead + $urandom_range(0, DEPTH - 1)) % DEPTH);
      applyStimulus();
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule

// File: doc/rob_multi.md
Name: rob_multi

Overview:
- Parametrised reorder buffer, successor to the single-commit ROB. Sits between issue, the execute/LSB writeback paths and commit.
- Power-of-two depth with all slots usable: an occupancy counter replaces the reserved-slot/empty-flag scheme.
- Generalised additions: NUM_WB writeback channels and in-order commit of up to COMMIT_W entries per cycle.
- Commit is serialised behind branches/jumps and stores.

Parameters:
- DEPTH_LOG2, 4, log2 of entry count (DEPTH = 2**DEPTH_LOG2).
- NUM_WB, 3, writeback channels (ALU, LSB read, LSB write).
- COMMIT_W, 2, max entries committed per cycle (1..4).
- DATA_W, 32, result width.
- ADDR_W, 32, jump target / pc width.
- ID_W, 6, instruction-id width.
- RD_W, 5, destination register index width.

Ports:
- clk_in  in  1  clock, rising edge.
- rst_n_in  in  1  reset, synchronous, active-low.
- rdy_in  in  1  global ready; when low, all state holds.
- clear_branch_in  in  1  flush on mispredict.
- issue_en_in  in  1  allocate one entry at tail.
- issue_id_in  in  ID_W  instruction id.
- issue_rd_in  in  RD_W  destination register.
- issue_store_in  in  1  entry is a store.
- issue_pc_in  in  ADDR_W  pc of instruction.
- tail_out  in/out: out  DEPTH_LOG2  index the next issue receives.
- head_out  out  DEPTH_LOG2  oldest entry index.
- full_out  out  1  count == DEPTH.
- empty_out  out  1  count == 0.
- wb_en_in  in  NUM_WB  per-channel writeback valid.
- wb_pos_in  in  NUM_WB*DEPTH_LOG2  entry index per channel.
- wb_res_in  in  NUM_WB*DATA_W  result per channel.
- wb_jump_en_in  in  NUM_WB  redirect taken.
- wb_jump_a_in  in  NUM_WB*ADDR_W  redirect target.
- rs1_pos_in, rs2_pos_in  in  DEPTH_LOG2 each  operand lookup indices.
- rs1_stall_out, rs2_stall_out  out  1 each  entry not ready.
- rs1_res_out, rs2_res_out  out  DATA_W each  entry result.
- commit_en_out  out  COMMIT_W  per-slot commit valid; slot 0 is oldest.
- commit_pos_out  out  COMMIT_W*DEPTH_LOG2  committed entry index.
- commit_id_out  out  COMMIT_W*ID_W  instruction id.
- commit_rd_out  out  COMMIT_W*RD_W  destination register.
- commit_res_out  out  COMMIT_W*DATA_W  result.
- commit_jump_en_out  out  COMMIT_W  redirect taken.
- commit_jump_a_out  out  COMMIT_W*ADDR_W  redirect target.

Behaviour:
- Priority per posedge: reset, then !rdy_in (hold everything, commit outputs included), then clear_branch_in, then normal operation.
- Reset (rst_n_in=0): head=tail=count=0; all valid/ready bits 0; commit_en_out=0. All other commit outputs are 0.
- clear_branch_in=1 with rdy_in=1: same state as reset. Issue, writeback and commit are ignored that cycle.
- full_out, empty_out, head_out, tail_out: combinational from registered head/tail/count.
- Issue: accepted iff issue_en_in && !full_out.
  - Writes entry[tail]: valid=1, ready=0, jump_en=0.
  - tail <= tail+1 modulo DEPTH (natural wrap).
  - Issue while full is dropped; no state change.
- Writeback channel c: if wb_en_in[c] && valid[pos], sets ready=1 and stores res/jump_en/jump_a.
  - Writeback to an invalid entry is ignored.
  - Two channels to the same pos in one cycle: highest channel index wins.
- Commit candidates: slot k looks at entry head+k (mod DEPTH). Slot k fires iff all of:
  - all slots <k fired;
  - k < count;
  - entry valid && ready;
  - no earlier slot this cycle has jump_en=1 or store=1.
  - A jump or store may itself commit in any slot; nothing younger commits that cycle.
- Fired slots register their outputs; commit_en_out is registered. Latency: writeback at edge N, commit_en_out high after edge N+1. Unfired slots drive commit_en_out=0.
- On commit: head advances by the number fired; those entries' valid and ready bits clear.
- count <= count + issued - committed.
  - Full + commit in the same cycle: issue is still rejected, because full_out uses the registered count.
  - Empty + issue: the new entry cannot commit before the following cycle (ready=0).
- Operand lookup: rsX_stall_out = !(valid && ready) at rsX_pos_in; rsX_res_out = stored res. Combinational.

Optional Feature:
- Macro: ROB_WB_BYPASS_EN.
- Defined: operand lookup forwards same-cycle writeback. If any wb_en_in[c] targets rsX_pos_in, then rsX_stall_out=0 and rsX_res_out=wb_res_in of the highest such c.
- Undefined: lookup reflects registered state only; stall clears one cycle after writeback.

Test Plan:
- Reset with rst_n_in=0 for 2 cycles, then issue 3 entries → tail_out=3, head_out=0, empty_out=0, commit_en_out=0.
- Issue 16 entries (DEPTH=16), then 1 more → full_out=1, 17th dropped, tail_out=0 (wrapped). Writeback pos 0 and 1 → next cycle commit_en_out=2'b11, head_out=2.
- Entries 0,1 ready; entry 0 wb_jump_en=1, jump_a=0x100 → only slot 0 commits with jump_a 0x100; entry 1 commits the following cycle.
- Channels 0 and 2 both write pos 5 (res 0xA, 0xB) → entry 5 res=0xB. Channel 1 writes an invalid entry → no change.
- 6 entries, 2 ready, then clear_branch_in=1 → next cycle count=0, empty_out=1, commit_en_out=0. Issue lands at index 0.
- With ROB_WB_BYPASS_EN: rs1_pos_in=3 while wb ch0 writes pos 3, res 0x55 → same cycle rs1_stall_out=0, rs1_res_out=0x55. Without the macro: stall=1 that cycle.
